komandara_axi4_slave: RTL and testbench

//   AXI4 full slave (burst-capable): terminates AXI4 bursts from an interconnect or master.

---
 rtl/komandara_axi4_slave.sv | 248 ++++++++++++++++++++++++
 tb/tb_komandara_axi4_slave.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/komandara_axi4_slave.sv
// AXI4 burst slave: turns FIXED/INCR/WRAP bursts into per-beat SRAM-style requests
// on independent write and read ports, with one outstanding transaction per channel.
module komandara_axi4_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // write address channel
    input  logic [ID_WIDTH-1:0]     s_axi_awid_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr_i,
    input  logic [7:0]              s_axi_awlen_i,
    input  logic [2:0]              s_axi_awsize_i,
    input  logic [1:0]              s_axi_awburst_i,
    input  logic                    s_axi_awvalid_i,
    output logic                    s_axi_awready_o,
    // write data channel
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb_i,
    input  logic                    s_axi_wlast_i,
    input  logic                    s_axi_wvalid_i,
    output logic                    s_axi_wready_o,
    // write response channel
    output logic [ID_WIDTH-1:0]     s_axi_bid_o,
    output logic [1:0]              s_axi_bresp_o,
    output logic                    s_axi_bvalid_o,
    input  logic                    s_axi_bready_i,
    // read address channel
    input  logic [ID_WIDTH-1:0]     s_axi_arid_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr_i,
    input  logic [7:0]              s_axi_arlen_i,
    input  logic [2:0]              s_axi_arsize_i,
    input  logic [1:0]              s_axi_arburst_i,
    input  logic                    s_axi_arvalid_i,
    output logic                    s_axi_arready_o,
    // read data channel
    output logic [ID_WIDTH-1:0]     s_axi_rid_o,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata_o,
    output logic [1:0]              s_axi_rresp_o,
    output logic                    s_axi_rlast_o,
    output logic                    s_axi_rvalid_o,
    input  logic                    s_axi_rready_i,
    // memory write port
    output logic                    mem_wr_req_o,
    input  logic                    mem_wr_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wr_data_o,
    output logic [DATA_WIDTH/8-1:0] mem_wr_be_o,
    // memory read port
    output logic                    mem_rd_req_o,
    input  logic                    mem_rd_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]  MAX_SIZE   = 3'($clog2(STRB_WIDTH));

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic burst_error(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == BURST_RSVD) || (size > MAX_SIZE) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    // Address of the beat following addr; all arithmetic wraps at 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [7:0] len,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] bytes;
        logic [ADDR_WIDTH-1:0] total;
        logic [ADDR_WIDTH-1:0] lower;
        logic [ADDR_WIDTH-1:0] incr;
        bytes = ADDR_WIDTH'(1) << size;
        total = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
        incr  = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
        lower = addr & ~(total - ADDR_WIDTH'(1));
        if (burst == BURST_FIXED) begin
            return addr;
        end else if (burst == BURST_WRAP) begin
            return (incr == lower + total) ? lower : incr;
        end
        return incr;
    endfunction

    // ---------------------------------------------------------------- write path
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

    wr_state_e             wr_state;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_len;
    logic [7:0]            wr_beat;
    logic [2:0]            wr_size;
    logic [1:0]            wr_burst;
    logic                  wr_err;
    logic                  wr_over;
    logic [1:0]            wr_resp;
    logic                  w_hs;

    // Error bursts and beats past len are drained without touching memory.
    assign s_axi_awready_o = (wr_state == WR_IDLE);
    assign s_axi_wready_o  = (wr_state == WR_DATA) && ((wr_err || wr_over) ? 1'b1 : mem_wr_gnt_i);
    assign mem_wr_req_o    = (wr_state == WR_DATA) && s_axi_wvalid_i && !wr_err && !wr_over;
    assign mem_wr_addr_o   = wr_addr;
    assign mem_wr_data_o   = s_axi_wdata_i;
    assign mem_wr_be_o     = s_axi_wstrb_i;
    assign s_axi_bvalid_o  = (wr_state == WR_RESP);
    assign s_axi_bid_o     = wr_id;
    assign s_axi_bresp_o   = wr_resp;
    assign w_hs            = s_axi_wvalid_i && s_axi_wready_o;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state <= WR_IDLE;
            wr_id    <= '0;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_beat  <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_err   <= 1'b0;
            wr_over  <= 1'b0;
            wr_resp  <= RESP_OKAY;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (s_axi_awvalid_i) begin
                        wr_id    <= s_axi_awid_i;
                        wr_addr  <= s_axi_awaddr_i;
                        wr_len   <= s_axi_awlen_i;
                        wr_size  <= s_axi_awsize_i;
                        wr_burst <= s_axi_awburst_i;
                        wr_err   <= burst_error(s_axi_awlen_i, s_axi_awsize_i, s_axi_awburst_i);
                        wr_beat  <= '0;
                        wr_over  <= 1'b0;
                        wr_state <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        if (s_axi_wlast_i) begin
                            wr_resp  <= (wr_err || wr_over || (wr_beat != wr_len)) ?
                                        RESP_SLVERR : RESP_OKAY;
                            wr_state <= WR_RESP;
                        end else if (wr_beat == wr_len) begin
                            wr_over <= 1'b1;
                        end else begin
                            wr_addr <= next_addr(wr_addr, wr_len, wr_size, wr_burst);
                            wr_beat <= wr_beat + 8'd1;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready_i) begin
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------------- read path
    typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_WAIT, RD_RESP} rd_state_e;

    rd_state_e             rd_state;
    logic [ID_WIDTH-1:0]   rd_id;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_len;
    logic [7:0]            rd_beat;
    logic [2:0]            rd_size;
    logic [1:0]            rd_burst;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_data;

    // R payload comes only from registers, so it holds still while rready is low.
    assign s_axi_arready_o = (rd_state == RD_IDLE);
    assign mem_rd_req_o    = (rd_state == RD_REQ) && !rd_err;
    assign mem_rd_addr_o   = rd_addr;
    assign s_axi_rvalid_o  = (rd_state == RD_RESP);
    assign s_axi_rid_o     = rd_id;
    assign s_axi_rdata_o   = rd_data;
    assign s_axi_rresp_o   = rd_err ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rlast_o   = (rd_beat == rd_len);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state <= RD_IDLE;
            rd_id    <= '0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_beat  <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (s_axi_arvalid_i) begin
                        rd_id    <= s_axi_arid_i;
                        rd_addr  <= s_axi_araddr_i;
                        rd_len   <= s_axi_arlen_i;
                        rd_size  <= s_axi_arsize_i;
                        rd_burst <= s_axi_arburst_i;
                        rd_err   <= burst_error(s_axi_arlen_i, s_axi_arsize_i, s_axi_arburst_i);
                        rd_beat  <= '0;
                        rd_state <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (rd_err || mem_rd_gnt_i) begin
                        rd_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    rd_data  <= rd_err ? '0 : mem_rd_data_i;
                    rd_state <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_axi_rready_i) begin
                        if (s_axi_rlast_o) begin
                            rd_state <= RD_IDLE;
                        end else begin
                            rd_addr  <= next_addr(rd_addr, rd_len, rd_size, rd_burst);
                            rd_beat  <= rd_beat + 8'd1;
                            rd_state <= RD_REQ;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_komandara_axi4_slave.sv
// Self-checking bench for komandara_axi4_slave: directed vector table, randomized bursts
// against an address/response model, and reset-during-read sequence.
module tb_komandara_axi4_slave;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] RSVD   = 2'b11;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  s_axi_awid_i = '0, s_axi_arid_i = '0;
    logic [31:0] s_axi_awaddr_i = '0, s_axi_araddr_i = '0;
    logic [7:0]  s_axi_awlen_i = '0, s_axi_arlen_i = '0;
    logic [2:0]  s_axi_awsize_i = '0, s_axi_arsize_i = '0;
    logic [1:0]  s_axi_awburst_i = '0, s_axi_arburst_i = '0;
    logic        s_axi_awvalid_i = 1'b0, s_axi_arvalid_i = 1'b0;
    logic        s_axi_awready_o, s_axi_arready_o;
    logic [31:0] s_axi_wdata_i = '0;
    logic [3:0]  s_axi_wstrb_i = '0;
    logic        s_axi_wlast_i = 1'b0, s_axi_wvalid_i = 1'b0, s_axi_wready_o;
    logic [3:0]  s_axi_bid_o, s_axi_rid_o;
    logic [1:0]  s_axi_bresp_o, s_axi_rresp_o;
    logic        s_axi_bvalid_o, s_axi_bready_i = 1'b0;
    logic [31:0] s_axi_rdata_o;
    logic        s_axi_rlast_o, s_axi_rvalid_o, s_axi_rready_i = 1'b0;
    logic        mem_wr_req_o, mem_wr_gnt_i = 1'b0;
    logic [31:0] mem_wr_addr_o, mem_wr_data_o;
    logic [3:0]  mem_wr_be_o;
    logic        mem_rd_req_o, mem_rd_gnt_i = 1'b0;
    logic [31:0] mem_rd_addr_o, mem_rd_data_i = '0;

    always #5 clk_i = ~clk_i;

    komandara_axi4_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_axi_awid_i(s_axi_awid_i), .s_axi_awaddr_i(s_axi_awaddr_i), .s_axi_awlen_i(s_axi_awlen_i),
        .s_axi_awsize_i(s_axi_awsize_i), .s_axi_awburst_i(s_axi_awburst_i),
        .s_axi_awvalid_i(s_axi_awvalid_i), .s_axi_awready_o(s_axi_awready_o),
        .s_axi_wdata_i(s_axi_wdata_i), .s_axi_wstrb_i(s_axi_wstrb_i), .s_axi_wlast_i(s_axi_wlast_i),
        .s_axi_wvalid_i(s_axi_wvalid_i), .s_axi_wready_o(s_axi_wready_o),
        .s_axi_bid_o(s_axi_bid_o), .s_axi_bresp_o(s_axi_bresp_o),
        .s_axi_bvalid_o(s_axi_bvalid_o), .s_axi_bready_i(s_axi_bready_i),
        .s_axi_arid_i(s_axi_arid_i), .s_axi_araddr_i(s_axi_araddr_i), .s_axi_arlen_i(s_axi_arlen_i),
        .s_axi_arsize_i(s_axi_arsize_i), .s_axi_arburst_i(s_axi_arburst_i),
        .s_axi_arvalid_i(s_axi_arvalid_i), .s_axi_arready_o(s_axi_arready_o),
        .s_axi_rid_o(s_axi_rid_o), .s_axi_rdata_o(s_axi_rdata_o), .s_axi_rresp_o(s_axi_rresp_o),
        .s_axi_rlast_o(s_axi_rlast_o), .s_axi_rvalid_o(s_axi_rvalid_o), .s_axi_rready_i(s_axi_rready_i),
        .mem_wr_req_o(mem_wr_req_o), .mem_wr_gnt_i(mem_wr_gnt_i), .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_wr_be_o(mem_wr_be_o),
        .mem_rd_req_o(mem_rd_req_o), .mem_rd_gnt_i(mem_rd_gnt_i), .mem_rd_addr_o(mem_rd_addr_o),
        .mem_rd_data_i(mem_rd_data_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within the cycle budget", name);
    endtask

    // ------------------------------------------------------------ reference model
    function automatic logic model_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        return (burst == RSVD) || (size > 3'd2) || ((burst == WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] a0, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst,
                                               input int k);
        longint bytes, total, lower, base;
        bytes = longint'(1) << size;
        total = bytes * (longint'(len) + 1);
        base  = longint'(a0);
        if (burst == FIXED || k == 0) return a0;
        if (burst == WRAP) begin
            lower = (base / total) * total;
            return 32'(lower + ((base - lower + longint'(k) * bytes) % total));
        end
        return 32'((base / bytes) * bytes + longint'(k) * bytes);
    endfunction

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    logic [31:0] exp_addr_q[$];

    task automatic fill_model(input logic [31:0] a0, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input int count);
        exp_addr_q.delete();
        for (int k = 0; k < count; k++) exp_addr_q.push_back(model_addr(a0, len, size, burst, k));
    endtask

    // ------------------------------------------------------ monitors and memory
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } wbeat_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;

    wbeat_t      wr_seen[$];
    logic [31:0] rd_seen[$];
    rbeat_t      r_seen[$];
    logic [5:0]  b_seen[$];
    bit          rd_pending = 0;
    logic [31:0] rd_pending_addr = '0;
    bit          r_stalled = 0;
    logic [39:0] r_hold = '0;

    // Inputs change at posedge+1, so values at negedge are what the next edge will sample.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (mem_wr_req_o && mem_wr_gnt_i)
                wr_seen.push_back('{mem_wr_addr_o, mem_wr_data_o, mem_wr_be_o});
            if (mem_rd_req_o && mem_rd_gnt_i) begin
                rd_seen.push_back(mem_rd_addr_o);
                rd_pending      = 1;
                rd_pending_addr = mem_rd_addr_o;
            end
            if (s_axi_bvalid_o && s_axi_bready_i) b_seen.push_back({s_axi_bid_o, s_axi_bresp_o});
            if (r_stalled)
                check("r_stable", 64'({s_axi_rvalid_o, s_axi_rid_o, s_axi_rresp_o, s_axi_rlast_o, s_axi_rdata_o}),
                      64'(r_hold));
            if (s_axi_rvalid_o && s_axi_rready_i)
                r_seen.push_back('{s_axi_rid_o, s_axi_rdata_o, s_axi_rresp_o, s_axi_rlast_o});
            r_stalled = s_axi_rvalid_o && !s_axi_rready_i;
            r_hold    = {s_axi_rvalid_o, s_axi_rid_o, s_axi_rresp_o, s_axi_rlast_o, s_axi_rdata_o};
        end else begin
            r_stalled = 0;
        end
    end

    // Memory responder: random grants and ready stalls; read data valid the cycle after grant.
    always @(posedge clk_i) begin
        #1;
        mem_wr_gnt_i   = ($urandom_range(0, 3) != 0);
        mem_rd_gnt_i   = ($urandom_range(0, 3) != 0);
        s_axi_bready_i = ($urandom_range(0, 2) != 0);
        s_axi_rready_i = ($urandom_range(0, 2) != 0);
        if (rd_pending) begin
            mem_rd_data_i = pattern(rd_pending_addr);
            rd_pending    = 0;
        end else begin
            mem_rd_data_i = $urandom;
        end
    end

    // ------------------------------------------------------------- master tasks
    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok = 0;
        @(posedge clk_i); #1;
        s_axi_awid_i = id; s_axi_awaddr_i = addr; s_axi_awlen_i = len;
        s_axi_awsize_i = size; s_axi_awburst_i = burst; s_axi_awvalid_i = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk_i); ok = s_axi_awready_o; end
        if (!ok) timeout("aw_timeout");
        @(posedge clk_i); #1;
        s_axi_awvalid_i = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok = 0;
        @(posedge clk_i); #1;
        s_axi_arid_i = id; s_axi_araddr_i = addr; s_axi_arlen_i = len;
        s_axi_arsize_i = size; s_axi_arburst_i = burst; s_axi_arvalid_i = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk_i); ok = s_axi_arready_o; end
        if (!ok) timeout("ar_timeout");
        @(posedge clk_i); #1;
        s_axi_arvalid_i = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit ok = 0;
        repeat ($urandom_range(0, 2)) @(posedge clk_i);
        @(posedge clk_i); #1;
        s_axi_wdata_i = data; s_axi_wstrb_i = strb; s_axi_wlast_i = last; s_axi_wvalid_i = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk_i); ok = s_axi_wready_o; end
        if (!ok) timeout("w_timeout");
        @(posedge clk_i); #1;
        s_axi_wvalid_i = 1'b0; s_axi_wlast_i = 1'b0;
    endtask

    // Expected memory write addresses come from exp_addr_q.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input logic [1:0] exp_resp);
        logic [31:0] dq[$];
        logic [3:0]  sq[$];
        logic [31:0] d;
        logic [3:0]  s;
        bit got = 0;
        wr_seen.delete(); b_seen.delete();
        aw_send(id, addr, len, size, burst);
        for (int b = 0; b < nbeats; b++) begin
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            dq.push_back(d); sq.push_back(s);
            w_send(d, s, b == nbeats - 1);
        end
        for (int n = 0; n < 200 && !got; n++) begin @(negedge clk_i); #1; got = (b_seen.size() != 0); end
        if (!got) begin timeout("b_timeout"); return; end
        check("b_id", 64'(b_seen[0][5:2]), 64'(id));
        check("b_resp", 64'(b_seen[0][1:0]), 64'(exp_resp));
        check("wr_count", 64'(wr_seen.size()), 64'(exp_addr_q.size()));
        for (int k = 0; k < wr_seen.size() && k < exp_addr_q.size(); k++) begin
            check("wr_addr", 64'(wr_seen[k].addr), 64'(exp_addr_q[k]));
            check("wr_data_be", 64'({wr_seen[k].data, wr_seen[k].be}), 64'({dq[k], sq[k]}));
        end
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp);
        bit got = 0;
        logic [31:0] exp_data;
        rd_seen.delete(); r_seen.delete();
        ar_send(id, addr, len, size, burst);
        for (int n = 0; n < 1000 && !got; n++) begin
            @(negedge clk_i); #1;
            got = (r_seen.size() >= int'(len) + 1);
        end
        if (!got) timeout("r_timeout");
        repeat (4) @(negedge clk_i);
        #1;
        check("r_count", 64'(r_seen.size()), 64'(int'(len) + 1));
        check("rd_mem_count", 64'(rd_seen.size()), 64'(exp_addr_q.size()));
        for (int k = 0; k < rd_seen.size() && k < exp_addr_q.size(); k++)
            check("rd_addr", 64'(rd_seen[k]), 64'(exp_addr_q[k]));
        for (int k = 0; k < r_seen.size() && k <= int'(len); k++) begin
            exp_data = (exp_resp == SLVERR || k >= exp_addr_q.size()) ? 32'h0 : pattern(exp_addr_q[k]);
            check("r_beat", 64'({r_seen[k].id, r_seen[k].resp, r_seen[k].last, r_seen[k].data}),
                  64'({id, exp_resp, (k == int'(len)), exp_data}));
        end
    endtask

    // ------------------------------------------------------------ vector table
    typedef struct {
        logic [3:0]        id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        int                nbeats;
        logic [1:0]        exp_bresp;
        logic [1:0]        exp_rresp;
        bit                rd_en;
        int                naddr;
        logic [3:0][31:0]  exp_addr;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                                input logic [1:0] bresp, input logic [1:0] rresp, input bit rd_en,
                                input int naddr, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.nbeats = nbeats;
        v.exp_bresp = bresp; v.exp_rresp = rresp; v.rd_en = rd_en; v.naddr = naddr;
        v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] addr;
        int          nbeats;
        int          nb;
        bit          err;
        bit          got;

        tbl[0]  = mk(4'd3,  32'h10,       8'd0, 3'd2, INCR,  1, OKAY,   OKAY,   1, 1, 32'h10, 0, 0, 0);
        tbl[1]  = mk(4'd5,  32'h100,      8'd3, 3'd2, INCR,  4, OKAY,   OKAY,   1, 4, 32'h100, 32'h104, 32'h108, 32'h10C);
        tbl[2]  = mk(4'd6,  32'h38,       8'd3, 3'd2, WRAP,  4, OKAY,   OKAY,   1, 4, 32'h38, 32'h3C, 32'h30, 32'h34);
        tbl[3]  = mk(4'd7,  32'h20,       8'd2, 3'd2, FIXED, 3, OKAY,   OKAY,   1, 3, 32'h20, 32'h20, 32'h20, 0);
        tbl[4]  = mk(4'd8,  32'h40,       8'd2, 3'd2, RSVD,  3, SLVERR, SLVERR, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(4'd9,  32'h40,       8'd2, 3'd2, WRAP,  3, SLVERR, SLVERR, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(4'd10, 32'h200,      8'd3, 3'd2, INCR,  2, SLVERR, OKAY,   0, 2, 32'h200, 32'h204, 0, 0);
        tbl[7]  = mk(4'd11, 32'h3,        8'd2, 3'd2, INCR,  3, OKAY,   OKAY,   1, 3, 32'h3, 32'h4, 32'h8, 0);
        tbl[8]  = mk(4'd12, 32'h80,       8'd0, 3'd3, INCR,  1, SLVERR, SLVERR, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(4'd1,  32'hFFFF_FFFC, 8'd1, 3'd2, INCR, 2, OKAY,   OKAY,   1, 2, 32'hFFFF_FFFC, 32'h0, 0, 0);
        tbl[10] = mk(4'd2,  32'h300,      8'd1, 3'd2, INCR,  3, SLVERR, OKAY,   1, 2, 32'h300, 32'h304, 0, 0);
        tbl[11] = mk(4'd4,  32'h5,        8'd3, 3'd0, WRAP,  4, OKAY,   OKAY,   1, 4, 32'h5, 32'h6, 32'h7, 32'h4);

        // Reset state
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_awready", 64'(s_axi_awready_o), 64'(1));
        check("rst_arready", 64'(s_axi_arready_o), 64'(1));
        check("rst_wready", 64'(s_axi_wready_o), 64'(0));
        check("rst_bvalid", 64'(s_axi_bvalid_o), 64'(0));
        check("rst_rvalid", 64'(s_axi_rvalid_o), 64'(0));
        check("rst_mem_req", 64'({mem_wr_req_o, mem_rd_req_o}), 64'(0));
        check("rst_regs", 64'({s_axi_bid_o, s_axi_rid_o, s_axi_rdata_o}), 64'(0));

        // W data offered before any AW must not be taken
        @(posedge clk_i); #1;
        s_axi_wvalid_i = 1'b1; s_axi_wlast_i = 1'b1; s_axi_wdata_i = 32'hCAFE_0000; s_axi_wstrb_i = 4'hF;
        repeat (3) begin
            @(negedge clk_i);
            check("w_before_aw", 64'({s_axi_wready_o, mem_wr_req_o}), 64'(0));
        end
        @(posedge clk_i); #1;
        s_axi_wvalid_i = 1'b0; s_axi_wlast_i = 1'b0;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            exp_addr_q.delete();
            for (int k = 0; k < tbl[i].naddr; k++) exp_addr_q.push_back(tbl[i].exp_addr[k]);
            do_write(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst,
                     tbl[i].nbeats, tbl[i].exp_bresp);
            if (tbl[i].rd_en)
                do_read(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, tbl[i].exp_rresp);
        end

        // Randomized bursts against the model
        for (int i = 0; i < 24; i++) begin
            burst = 2'($urandom_range(0, 3));
            size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if (burst == WRAP) begin
                case ($urandom_range(0, 4))
                    0: len = 8'd1;
                    1: len = 8'd2;
                    2: len = 8'd3;
                    3: len = 8'd7;
                    default: len = 8'd15;
                endcase
            end else begin
                len = 8'($urandom_range(0, 15));
            end
            addr = $urandom;
            if (burst == WRAP && size <= 3'd2) addr = addr & ~((32'd1 << size) - 32'd1);
            nbeats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(len) + 2) : int'(len) + 1;
            err = model_err(len, size, burst);
            fill_model(addr, len, size, burst, err ? 0 : ((nbeats < int'(len) + 1) ? nbeats : int'(len) + 1));
            do_write(4'($urandom), addr, len, size, burst, nbeats,
                     (err || nbeats != int'(len) + 1) ? SLVERR : OKAY);
            fill_model(addr, len, size, burst, err ? 0 : int'(len) + 1);
            do_read(4'($urandom), addr, len, size, burst, err ? SLVERR : OKAY);
        end

        // Reset asserted in the middle of a read burst
        r_seen.delete();
        ar_send(4'hC, 32'h400, 8'd7, 3'd2, INCR);
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin @(negedge clk_i); #1; got = (r_seen.size() >= 2); end
        if (!got) timeout("mid_read_timeout");
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_rvalid", 64'(s_axi_rvalid_o), 64'(0));
        check("rst_mid_arready", 64'(s_axi_arready_o), 64'(1));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        nb = r_seen.size();
        repeat (10) @(negedge clk_i);
        #1;
        check("post_rst_rvalid", 64'(s_axi_rvalid_o), 64'(0));
        check("post_rst_arready", 64'(s_axi_arready_o), 64'(1));
        check("post_rst_rd_req", 64'(mem_rd_req_o), 64'(0));
        check("post_rst_no_r", 64'(r_seen.size()), 64'(nb));

        // Path still usable after the abandoned burst
        fill_model(32'h500, 8'd1, 3'd2, INCR, 2);
        do_read(4'h3, 32'h500, 8'd1, 3'd2, INCR, OKAY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
